// File: rtl/video_pattern_gen.sv
// Synthetic raster source (IDLE/RUN/DRAIN) with sync decode, coordinates and luma test patterns.
// Optional VPG_SCROLL_EN adds a per-frame counter that scrolls the ramps and flips the checkerboard.
module video_pattern_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic [1:0]  pattern_i,
  input  logic [7:0]  level_i,
  output logic [7:0]  y_o,
  output logic        dv_o,
  output logic        hs_o,
  output logic        vs_o,
  output logic [10:0] x_o,
  output logic [9:0]  line_o,
  output logic        frame_start_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic [1:0]  pat_q, pat_d;
  logic [7:0]  lvl_q, lvl_d;
  logic [7:0]  y_q, y_d;
  logic        dv_q, dv_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  line_q, line_d;

  logic        running, wrap, frame0, dv_c;
  logic [1:0]  cur_pat;
  logic [7:0]  cur_lvl, y_calc, scroll;
  logic        inv;

`ifdef VPG_SCROLL_EN
  logic [7:0] fcnt_q, fcnt_d;
  assign scroll = fcnt_q;
  assign inv    = fcnt_q[0];
`else
  assign scroll = 8'd0;
  assign inv    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    pat_d   = pat_q;
    lvl_d   = lvl_q;
    running = (state_q != ST_IDLE);
    wrap    = (h_q == H_LAST) && (v_q == V_LAST);
    frame0  = running && (h_q == 11'd0) && (v_q == 10'd0);

    case (state_q)
      ST_IDLE: begin
        h_d = 11'd0;
        v_d = 10'd0;
        if (en_i) begin
          state_d = ST_RUN;
          pat_d   = pattern_i;
          lvl_d   = level_i;
        end
      end
      ST_RUN:   if (!en_i) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (en_i)      state_d = ST_RUN;
        else if (wrap) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase

    if (running) begin
      if (h_q == H_LAST) begin
        h_d = 11'd0;
        v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 11'd1;
      end
    end
    if (frame0) begin
      pat_d = pattern_i;
      lvl_d = level_i;
    end

    // The frame-start pixel already uses the freshly sampled selection.
    cur_pat = frame0 ? pattern_i : pat_q;
    cur_lvl = frame0 ? level_i : lvl_q;
    dv_c    = (h_q < H_ACT) && (v_q < V_ACT);
    case (cur_pat)
      2'd0:    y_calc = h_q[7:0] + scroll;
      2'd1:    y_calc = v_q[7:0] + scroll;
      2'd2:    y_calc = (h_q[3] ^ v_q[3] ^ inv) ? 8'hFF : 8'h00;
      default: y_calc = cur_lvl;
    endcase

    y_d    = (running && dv_c) ? y_calc : 8'd0;
    dv_d   = running && dv_c;
    hs_d   = running && (h_q >= HS_BEG) && (h_q < HS_END);
    vs_d   = running && (v_q >= VS_BEG) && (v_q < VS_END);
    x_d    = running ? h_q : 11'd0;
    line_d = running ? v_q : 10'd0;
    fs_d   = frame0;
`ifdef VPG_SCROLL_EN
    fcnt_d = (running && wrap) ? fcnt_q + 8'd1 : fcnt_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      pat_q   <= '0;
      lvl_q   <= '0;
      y_q     <= '0;
      dv_q    <= 1'b0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      fs_q    <= 1'b0;
      x_q     <= '0;
      line_q  <= '0;
`ifdef VPG_SCROLL_EN
      fcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      pat_q   <= pat_d;
      lvl_q   <= lvl_d;
      y_q     <= y_d;
      dv_q    <= dv_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      x_q     <= x_d;
      line_q  <= line_d;
`ifdef VPG_SCROLL_EN
      fcnt_q  <= fcnt_d;
`endif
    end
  end

  assign y_o           = y_q;
  assign dv_o          = dv_q;
  assign hs_o          = hs_q;
  assign vs_o          = vs_q;
  assign x_o           = x_q;
  assign line_o        = line_q;
  assign frame_start_o = fs_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Bench for video_pattern_gen on a 14x7 raster: an expected-output queue is filled per frame
// and compared every cycle; VPG_SCROLL_EN changes the expected ramp/checker values.
module tb_video_pattern_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_i = 1'b0;
  logic [1:0]  pattern_i = 2'd0;
  logic [7:0]  level_i = 8'd0;
  logic [7:0]  y_o;
  logic        dv_o, hs_o, vs_o, frame_start_o;
  logic [10:0] x_o;
  logic [9:0]  line_o;

  video_pattern_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .pattern_i(pattern_i), .level_i(level_i),
    .y_o(y_o), .dv_o(dv_o), .hs_o(hs_o), .vs_o(vs_o), .x_o(x_o), .line_o(line_o),
    .frame_start_o(frame_start_o)
  );

  always #5 clk = ~clk;

  // {frame_start, dv, hs, vs, y[7:0], x[10:0], line[9:0]}
  localparam int W = 33;
  logic [W-1:0] exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           cyc = 0;
  int           fs_cyc[$];
  int           vs_cnt = 0;
  logic [7:0]   fr = 8'd0;

  function automatic logic [W-1:0] exp_px(int x, int l, int pat, logic [7:0] lvl, logic [7:0] fc);
    logic dv, hs, vs, fs, chk;
    logic [7:0] y, xb, lb, sc;
    dv = (x < 8) && (l < 4);
    hs = (x >= 10) && (x < 12);
    vs = (l == 5);
    fs = (x == 0) && (l == 0);
    xb = 8'(x);
    lb = 8'(l);
`ifdef VPG_SCROLL_EN
    sc = fc;
`else
    sc = 8'd0;
`endif
    chk = (((x / 8) % 2) != ((l / 8) % 2)) ^ sc[0];
    case (pat)
      0:       y = xb + sc;
      1:       y = lb + sc;
      2:       y = chk ? 8'hFF : 8'h00;
      default: y = lvl;
    endcase
    if (!dv) y = 8'd0;
    return {fs, dv, hs, vs, y, 11'(x), 10'(l)};
  endfunction

  task automatic push_zero(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('0);
  endtask

  task automatic push_frame(input int pat, input logic [7:0] lvl);
    for (int l = 0; l < 7; l++)
      for (int x = 0; x < 14; x++)
        exp_q.push_back(exp_px(x, l, pat, lvl, fr));
    fr = fr + 8'd1;
  endtask

  task automatic check_cycles(input int n);
    logic [W-1:0] act, exp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      act = {frame_start_o, dv_o, hs_o, vs_o, y_o, x_o, line_o};
      if (act[W-1]) fs_cyc.push_back(cyc);
      if (act[W-4]) vs_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL queue_empty cycle=%0d actual=%h required=expected entry", cyc, act);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          bad++;
          $display("FAIL stream cycle=%0d actual=%h required=%h", cyc, act, exp);
        end
      end
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    total++;
    if ({frame_start_o, dv_o, hs_o, vs_o, y_o, x_o, line_o} !== '0) begin
      bad++;
      $display("FAIL reset_state actual=%h required=0", {frame_start_o, dv_o, hs_o, vs_o, y_o, x_o, line_o});
    end
    @(negedge clk);
    rst = 1'b0;
    push_zero(3);
    check_cycles(3);
  endtask

  task automatic test_ramp;
    pattern_i = 2'd0;
    en_i = 1'b1;
    fs_cyc.delete();
    vs_cnt = 0;
    push_zero(1);
    push_frame(0, 8'd0);
    push_frame(0, 8'd0);
    check_cycles(197);
    total++;
    if (fs_cyc.size() != 2 || fs_cyc[1] - fs_cyc[0] != 98) begin
      bad++;
      $display("FAIL frame_start_spacing actual_count=%0d required=2 spacing 98", fs_cyc.size());
    end
    total++;
    if (vs_cnt != 28) begin
      bad++;
      $display("FAIL vsync_cycles actual=%0d required=28", vs_cnt);
    end
  endtask

  task automatic test_checker_change;
    pattern_i = 2'd2;
    push_frame(2, 8'd0);
    check_cycles(49);
    pattern_i = 2'd3;
    level_i = 8'h5A;
    check_cycles(49);
    push_frame(3, 8'h5A);
    check_cycles(98);
  endtask

  task automatic test_stop_restart;
    push_frame(3, 8'h5A);
    check_cycles(15);
    en_i = 1'b0;
    check_cycles(83);
    push_zero(10);
    check_cycles(10);
    en_i = 1'b1;
    push_zero(1);
    push_frame(3, 8'h5A);
    push_frame(3, 8'h5A);
    check_cycles(30);
    en_i = 1'b0;
    check_cycles(14);
    en_i = 1'b1;
    check_cycles(153);
  endtask

  task automatic test_reset_mid_frame;
    push_frame(3, 8'h5A);
    check_cycles(32);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({frame_start_o, dv_o, hs_o, vs_o, y_o, x_o, line_o} !== '0) begin
      bad++;
      $display("FAIL async_reset actual=%h required=0", {frame_start_o, dv_o, hs_o, vs_o, y_o, x_o, line_o});
    end
    exp_q.delete();
    fr = 8'd0;
    push_zero(2);
    check_cycles(2);
    rst = 1'b0;
    pattern_i = 2'd1;
    push_zero(1);
    push_frame(1, 8'h5A);
    check_cycles(99);
  endtask

  task automatic test_long_run;
    pattern_i = 2'd0;
    for (int f = 0; f < 258; f++) begin
      push_frame(0, 8'h5A);
      check_cycles(98);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_checker_change();
    test_stop_restart();
    test_reset_mid_frame();
    test_long_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
